// File: rtl/ws2812_pkg.sv
// Shared types, timing defaults and channel scaling helpers for the WS2812 frame scheduler.
package ws2812_pkg;

    typedef logic [23:0] pixel_t;

    localparam int G_LSB = 16;
    localparam int R_LSB = 8;
    localparam int B_LSB = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        LATCH = 2'd2
    } state_t;

    // 80 us latch gap and 60 Hz refresh on the 48 MHz PLL clock
    localparam int DEF_LATCH_CYCLES   = 3840;
    localparam int DEF_REFRESH_CYCLES = 800000;

    function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] prod;
        prod = 16'(c) * (16'(b) + 16'd1);
        return 8'(prod >> 8);
    endfunction

    function automatic pixel_t scale_pixel(input pixel_t p, input logic [7:0] b);
        return {scale_chan(p[G_LSB +: 8], b),
                scale_chan(p[R_LSB +: 8], b),
                scale_chan(p[B_LSB +: 8], b)};
    endfunction

endpackage

// File: rtl/ws2812_frame_sched_if.sv
// Host write port plus pixel stream of the WS2812 frame scheduler.
// The bright field exists only when WS2812_BRIGHTNESS_EN is defined.
interface ws2812_frame_sched_if #(parameter int AW = 3);
    import ws2812_pkg::*;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    pixel_t        wr_data;
    logic          wr_ready;
    logic          commit;
    pixel_t        pix_data;
    logic          pix_valid;
    logic          pix_ready;
    logic          busy;
    logic          frame_done;
`ifdef WS2812_BRIGHTNESS_EN
    logic [7:0]    bright;
`endif

    modport master (
`ifdef WS2812_BRIGHTNESS_EN
        output bright,
`endif
        output wr_en, wr_addr, wr_data, commit, pix_ready,
        input  wr_ready, pix_data, pix_valid, busy, frame_done
    );

    modport slave (
`ifdef WS2812_BRIGHTNESS_EN
        input  bright,
`endif
        input  wr_en, wr_addr, wr_data, commit, pix_ready,
        output wr_ready, pix_data, pix_valid, busy, frame_done
    );

endinterface

// File: rtl/ws2812_pixel_buf.sv
// NUM_LEDS x 24-bit pixel store: one synchronous write port, one asynchronous read port.
module ws2812_pixel_buf
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS = 8,
    parameter int AW       = $clog2(NUM_LEDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  pixel_t        wdata,
    input  logic [AW-1:0] raddr,
    output pixel_t        rdata
);

    pixel_t mem_r [NUM_LEDS];

    // Pixel store; addresses beyond NUM_LEDS-1 match no entry and are dropped
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (we && (waddr == AW'(i))) begin
                mem_r[i] <= wdata;
            end
        end
    end

    // Asynchronous read mux
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (raddr == AW'(i)) begin
                rdata = mem_r[i];
            end else begin
                rdata = rdata;
            end
        end
    end

endmodule

// File: rtl/ws2812_frame_sched.sv
// Frame scheduler in front of the WS2812 serializer: commit/refresh scheduling, pixel streaming, latch gap.
// Optional per-frame brightness scaling is enabled by defining WS2812_BRIGHTNESS_EN.
module ws2812_frame_sched
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS       = 8,
    parameter int LATCH_CYCLES   = DEF_LATCH_CYCLES,
    parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES,
    parameter int AW             = $clog2(NUM_LEDS)
) (
    input  logic               clk,
    input  logic               rst,
    ws2812_frame_sched_if.slave bus
);

    localparam int LCW = $clog2(LATCH_CYCLES + 1);
    localparam int TCW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [AW:0] NUM_LEDS_W = (AW + 1)'(NUM_LEDS);

    state_t         state_r, state_s;
    logic [AW-1:0]  idx_r, idx_s;
    logic [LCW-1:0] lcnt_r, lcnt_s;
    logic           commit_pend_r, commit_pend_s;
    logic           refresh_pend_r, refresh_pend_s;
    logic           frame_done_r, frame_done_s;
    logic           wrap_s;
    logic           we_s;
    pixel_t         rd_pix_s;

    generate
        if (REFRESH_CYCLES > 0) begin : g_refresh
            logic [TCW-1:0] tmr_r;

            // Free-running refresh period counter, independent of the frame state
            always_ff @(posedge clk) begin
                if (!rst) begin
                    tmr_r <= '0;
                end else if (tmr_r == TCW'(REFRESH_CYCLES - 1)) begin
                    tmr_r <= '0;
                end else begin
                    tmr_r <= tmr_r + 1'b1;
                end
            end

            assign wrap_s = (tmr_r == TCW'(REFRESH_CYCLES - 1));
        end else begin : g_no_refresh
            assign wrap_s = 1'b0;
        end
    endgenerate

    // Writes are only accepted while idle, so a frame never sees a torn buffer
    assign we_s = bus.wr_en && (state_r == IDLE) && ({1'b0, bus.wr_addr} < NUM_LEDS_W);

    ws2812_pixel_buf #(
        .NUM_LEDS (NUM_LEDS),
        .AW       (AW)
    ) u_buf (
        .clk   (clk),
        .we    (we_s),
        .waddr (bus.wr_addr),
        .wdata (bus.wr_data),
        .raddr (idx_r),
        .rdata (rd_pix_s)
    );

`ifdef WS2812_BRIGHTNESS_EN
    logic [7:0] bright_r, bright_s;
`endif

    // Next-state, pixel index, latch counter and request flag logic
    always_comb begin
        state_s        = state_r;
        idx_s          = idx_r;
        lcnt_s         = lcnt_r;
        commit_pend_s  = commit_pend_r || (bus.commit && (state_r != IDLE));
        refresh_pend_s = refresh_pend_r || wrap_s;
        frame_done_s   = 1'b0;
`ifdef WS2812_BRIGHTNESS_EN
        bright_s       = bright_r;
`endif
        case (state_r)
            IDLE: begin
                if (commit_pend_r || refresh_pend_r || bus.commit) begin
                    // One frame absorbs every request outstanding at this point
                    state_s        = SEND;
                    idx_s          = '0;
                    commit_pend_s  = 1'b0;
                    refresh_pend_s = 1'b0;
`ifdef WS2812_BRIGHTNESS_EN
                    bright_s       = bus.bright;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                if (bus.pix_ready) begin
                    if (idx_r == AW'(NUM_LEDS - 1)) begin
                        state_s = LATCH;
                        lcnt_s  = LCW'(LATCH_CYCLES - 1);
                    end else begin
                        idx_s = idx_r + 1'b1;
                    end
                end else begin
                    state_s = SEND;
                end
            end
            LATCH: begin
                if (lcnt_r == '0) begin
                    state_s      = IDLE;
                    idx_s        = '0;
                    frame_done_s = 1'b1;
                end else begin
                    lcnt_s = lcnt_r - 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
                idx_s   = '0;
            end
        endcase
    end

    // Control registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r        <= IDLE;
            idx_r          <= '0;
            lcnt_r         <= '0;
            commit_pend_r  <= 1'b0;
            refresh_pend_r <= 1'b0;
            frame_done_r   <= 1'b0;
`ifdef WS2812_BRIGHTNESS_EN
            bright_r       <= 8'd0;
`endif
        end else begin
            state_r        <= state_s;
            idx_r          <= idx_s;
            lcnt_r         <= lcnt_s;
            commit_pend_r  <= commit_pend_s;
            refresh_pend_r <= refresh_pend_s;
            frame_done_r   <= frame_done_s;
`ifdef WS2812_BRIGHTNESS_EN
            bright_r       <= bright_s;
`endif
        end
    end

    assign bus.pix_valid  = (state_r == SEND);
    assign bus.busy       = (state_r != IDLE);
    assign bus.wr_ready   = (state_r == IDLE);
    assign bus.frame_done = frame_done_r;
`ifdef WS2812_BRIGHTNESS_EN
    assign bus.pix_data   = scale_pixel(rd_pix_s, bright_r);
`else
    assign bus.pix_data   = rd_pix_s;
`endif

endmodule

// File: tb/tb_ws2812_frame_sched.sv
// Self-checking bench for ws2812_frame_sched: directed frames, backpressure, locking, merging, refresh, reset.
module tb_ws2812_frame_sched;
    import ws2812_pkg::*;

    localparam int NA = 8;
    localparam int LA = 3840;
    localparam int NB = 6;
    localparam int LB = 10;
    localparam int RB = 1000;

    logic clk;
    logic rst_a, rst_b;
    int   n_pass, n_total, cyc;
    pixel_t model_a [NA];
    pixel_t model_b [NB];

    ws2812_frame_sched_if #(.AW(3)) ifa ();
    ws2812_frame_sched_if #(.AW(3)) ifb ();

    ws2812_frame_sched #(.NUM_LEDS(NA), .LATCH_CYCLES(LA), .REFRESH_CYCLES(0)) dut_a (
        .clk (clk), .rst (rst_a), .bus (ifa));

    ws2812_frame_sched #(.NUM_LEDS(NB), .LATCH_CYCLES(LB), .REFRESH_CYCLES(RB)) dut_b (
        .clk (clk), .rst (rst_b), .bus (ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic pixel_t ref_pix(input pixel_t p, input int b);
`ifdef WS2812_BRIGHTNESS_EN
        int g, r, bl;
        g  = (int'(p[23:16]) * (b + 1)) / 256;
        r  = (int'(p[15:8])  * (b + 1)) / 256;
        bl = (int'(p[7:0])   * (b + 1)) / 256;
        return {8'(g), 8'(r), 8'(bl)};
`else
        return (b >= 0) ? p : p;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wr_a(input int a, input pixel_t d);
        ifa.wr_en   = 1'b1;
        ifa.wr_addr = 3'(a);
        ifa.wr_data = d;
        check("wr_ready_idle", ifa.wr_ready, 1);
        tick();
        ifa.wr_en = 1'b0;
        model_a[a] = d;
    endtask

    // Streams one frame of dut_a (already started) and measures the latch gap up to frame_done.
    task automatic run_frame_a(input int stall_idx, input int stall_len,
                               input bit wr_send, input bit gap_commits);
        pixel_t exp_pix [NA];
        int br, hs, st, n, g, bad_v, bad_b;
        br = 255;
`ifdef WS2812_BRIGHTNESS_EN
        br = int'(ifa.bright);
`endif
        for (int i = 0; i < NA; i++) exp_pix[i] = ref_pix(model_a[i], br);
        hs = 0; st = 0; n = 0;
        while (hs < NA && n < NA + 64) begin
            ifa.pix_ready = !(hs == stall_idx && st < stall_len);
`ifdef WS2812_BRIGHTNESS_EN
            if (hs == 2) ifa.bright = 8'($urandom_range(0, 255));
`endif
            if (wr_send && hs == 1) begin
                ifa.wr_en   = 1'b1;
                ifa.wr_addr = 3'd0;
                ifa.wr_data = 24'h123456;
                check("wr_ready_in_send", ifa.wr_ready, 0);
            end else begin
                ifa.wr_en = 1'b0;
            end
            if (!ifa.pix_ready) begin
                check("stall_valid", ifa.pix_valid, 1);
                check("stall_data", ifa.pix_data, exp_pix[hs]);
                st++;
            end else if (ifa.pix_valid) begin
                check($sformatf("pix%0d", hs), ifa.pix_data, exp_pix[hs]);
                hs++;
            end
            tick();
            n++;
        end
        ifa.wr_en = 1'b0;
        ifa.pix_ready = 1'b1;
        check("handshakes", hs, NA);
        g = 0; bad_v = 0; bad_b = 0;
        while (!ifa.frame_done && g < LA + 16) begin
            if (ifa.pix_valid) bad_v++;
            if (!ifa.busy) bad_b++;
            ifa.commit = gap_commits && (g == 5 || g == 100);
            tick();
            g++;
        end
        ifa.commit = 1'b0;
        check("latch_gap_len", g, LA);
        check("latch_valid_low", bad_v, 0);
        check("latch_busy_high", bad_b, 0);
        check("fd_busy_low", ifa.busy, 0);
        check("fd_wr_ready", ifa.wr_ready, 1);
    endtask

    task automatic wait_rise_b(output int t);
        bit found, prev;
        int n;
        found = 1'b0; n = 0; prev = ifb.pix_valid;
        while (!found && n < 2100) begin
            tick();
            n++;
            if (ifb.pix_valid && !prev) found = 1'b1;
            prev = ifb.pix_valid;
        end
        t = cyc;
        check("rise_b_seen", found, 1);
    endtask

    initial begin
        int s0, s1, hs, n, bad, rises;
        bit prev;
        n_pass = 0; n_total = 0; cyc = 0;
        rst_a = 1'b0; rst_b = 1'b0;
        ifa.wr_en = 1'b0; ifa.wr_addr = '0; ifa.wr_data = '0; ifa.commit = 1'b0; ifa.pix_ready = 1'b0;
        ifb.wr_en = 1'b0; ifb.wr_addr = '0; ifb.wr_data = '0; ifb.commit = 1'b0; ifb.pix_ready = 1'b1;
`ifdef WS2812_BRIGHTNESS_EN
        ifa.bright = 8'd127;
        ifb.bright = 8'd255;
`endif
        for (int i = 0; i < NA; i++) model_a[i] = '0;
        for (int i = 0; i < NB; i++) model_b[i] = '0;
        repeat (3) tick();
        check("rst_pix_valid", ifa.pix_valid, 0);
        check("rst_busy", ifa.busy, 0);
        check("rst_frame_done", ifa.frame_done, 0);
        check("rst_wr_ready", ifa.wr_ready, 1);
        check("rst_b_busy", ifb.busy, 0);
        rst_a = 1'b1; rst_b = 1'b1;

        // dut_b buffer, including two out-of-range addresses that must be ignored
        for (int i = 0; i < 8; i++) begin
            ifb.wr_en   = 1'b1;
            ifb.wr_addr = 3'(i);
            ifb.wr_data = 24'($urandom);
            if (i < NB) model_b[i] = ifb.wr_data;
            tick();
        end
        ifb.wr_en = 1'b0;

        // Frame 1: three primaries plus a brightness reference pixel
        wr_a(0, 24'hFF0000);
        wr_a(1, 24'h00FF00);
        wr_a(2, 24'h0000FF);
        wr_a(3, 24'hFF8040);
        ifa.commit = 1'b1; ifa.pix_ready = 1'b1;
        check("pre_commit_idle", ifa.busy, 0);
        tick();
        ifa.commit = 1'b0;
        check("first_valid_f1", ifa.pix_valid, 1);
        run_frame_a(-1, 0, 1'b0, 1'b0);
        tick();
        check("fd_single_pulse", ifa.frame_done, 0);
        check("idle_after_f1", ifa.busy, 0);

        // Frame 2: random pixels, stall at idx 3, dropped write, two commits in the gap
        for (int i = 0; i < NA; i++) wr_a(i, 24'($urandom));
        ifa.commit = 1'b1;
        tick();
        ifa.commit = 1'b0;
        check("first_valid_f2", ifa.pix_valid, 1);
        run_frame_a(3, 5, 1'b1, 1'b1);

        // Write in the same cycle the pending frame starts: it must be visible
        ifa.wr_en   = 1'b1;
        ifa.wr_addr = 3'd5;
        ifa.wr_data = 24'($urandom);
        model_a[5]  = ifa.wr_data;
        tick();
        ifa.wr_en = 1'b0;
        check("pend_start_valid", ifa.pix_valid, 1);
        run_frame_a(-1, 0, 1'b0, 1'b0);
        bad = 0;
        repeat (20) begin
            tick();
            if (ifa.busy || ifa.frame_done) bad++;
        end
        check("no_extra_frame", bad, 0);

        // Reset in the middle of a frame at idx 4
        ifa.commit = 1'b1;
        tick();
        ifa.commit = 1'b0;
        hs = 0; n = 0;
        while (hs < 4 && n < 20) begin
            if (ifa.pix_valid) hs++;
            tick();
            n++;
        end
        check("pre_reset_valid", ifa.pix_valid, 1);
        rst_a = 1'b0;
        tick();
        check("mid_rst_valid", ifa.pix_valid, 0);
        check("mid_rst_busy", ifa.busy, 0);
        check("mid_rst_wr_ready", ifa.wr_ready, 1);
        check("mid_rst_frame_done", ifa.frame_done, 0);
        rst_a = 1'b1;
        bad = 0;
        repeat (LA + 20) begin
            tick();
            if (ifa.busy || ifa.frame_done || ifa.pix_valid) bad++;
        end
        check("frame_lost_after_rst", bad, 0);

        // dut_b: periodic refresh frames and commit coincident with a wrap
        wait_rise_b(s0);
        for (int i = 0; i < NB; i++) begin
            check($sformatf("b_pix%0d", i), ifb.pix_data, ref_pix(model_b[i], 255));
            tick();
        end
        check("b_end_of_frame", ifb.pix_valid, 0);
        wait_rise_b(s1);
        check("refresh_period", s1 - s0, RB);
        while (cyc < s1 + RB - 2) tick();
        check("b_idle_before_wrap", ifb.busy, 0);
        ifb.commit = 1'b1;
        tick();
        ifb.commit = 1'b0;
        check("coincident_start", ifb.pix_valid, 1);
        prev = 1'b1; rises = 0;
        repeat (300) begin
            tick();
            if (ifb.pix_valid && !prev) rises++;
            prev = ifb.pix_valid;
        end
        check("coincident_one_frame", rises, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
